data_mem_stage: RTL and testbench
=================================

Name: data_mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage (register file, operand muxes and ALU).
- Consumes ALUResult as the byte address and RD2 as store data. Performs RV32I loads and stores (byte, half, word, with sign/zero extension) on an internal byte-addressed RAM.
- Produces ReadData for the writeback mux.
- A wait-state FSM models memory latency and drives Stall back to the PC/fetch logic.

Parameters:
- ADDR_WIDTH, 17, byte-address bits decoded. Upper address bits are ignored, so addresses alias modulo 2^ADDR_WIDTH.
- WAIT_CYCLES, 1, extra stall cycles before an access commits (0..15).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- MemRead  input  1  load request.
- MemWrite  input  1  store request.
- funct3  input  3  access size/sign. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- ALUResult  input  32  byte address from the ALU.
- WriteData  input  32  store data (RD2); low bytes used for SB/SH.
- ReadData  output  32  extended load result.
- Stall  output  1  upstream must hold PC and all stage inputs stable while high.
- Valid  output  1  one-cycle pulse: access completed this cycle.
- Error  output  1  one-cycle pulse: misaligned access, illegal funct3, or MemRead&MemWrite both high.

Behaviour:
- Reset:
  - State IDLE, wait counter 0, ReadData 0, Stall 0, Valid 0, Error 0.
  - RAM contents are not cleared.
- A request is MemRead or MemWrite high in IDLE.
- FSM states: IDLE, WAIT, DONE.
- IDLE, no request: outputs Stall 0, Valid 0, Error 0.
- IDLE, illegal request (misaligned, bad funct3, or both strobes high):
  - Error 1 in the same cycle, combinational from inputs.
  - Stall 0; no RAM access; remain IDLE.
  - Misaligned means half with addr[0]=1, or word with addr[1:0]≠0.
- IDLE, legal request:
  - Stall 1 combinationally in that cycle (T0).
  - Load counter with WAIT_CYCLES and go to WAIT.
  - If WAIT_CYCLES=0, the access commits at the end of T0 and the FSM goes directly to DONE.
- WAIT:
  - Stall 1; counter decrements each cycle.
  - On the cycle the counter reads 1, the access commits at that cycle's closing edge and the FSM goes to DONE.
- Commit rules:
  - Store: RAM bytes are written little-endian at the aligned address.
  - Load: ReadData is registered, with sign- or zero-extension per funct3.
- DONE:
  - Stall 0, Valid 1, for exactly one cycle; then IDLE.
  - Inputs are not sampled in DONE, so the still-held request is not re-issued.
- Total access cost is WAIT_CYCLES+2 cycles. Stall is high for exactly WAIT_CYCLES+1 cycles.
- ReadData holds its value until the next load commits; stores do not change it.
- Request inputs changing while Stall=1 is an upstream error. The stage uses only values sampled at the commit edge.
- Reset mid-operation: return to IDLE immediately. A store is not written unless its commit edge has already passed.
- Simultaneous rst and commit edge: rst wins, and the store is not written.
- Address wrap: address 2^ADDR_WIDTH aliases address 0.

Test Plan:
- WAIT_CYCLES=1; SW 0xDEADBEEF @0x100, then LW @0x100 → ReadData=0xDEADBEEF, Valid pulses once per access, Stall high 2 cycles each.
- After the above: LB @0x103 → 0xFFFFFFDE; LBU @0x103 → 0x000000DE; LH @0x102 → 0xFFFFDEAD; LHU @0x102 → 0x0000DEAD.
- SB WriteData=0x12345655 @0x101, then LW @0x100 → 0xDEAD55EF; only byte 1 changed.
- LW @0x102 and SH @0x101 → Error=1 for one cycle, Stall=0, Valid=0; a following LW @0x100 returns the unchanged word.
- WAIT_CYCLES=3; LW @0x0 → Stall high exactly 4 cycles, Valid in cycle 5, then IDLE with no re-issue though MemRead is still high in DONE.
- SW 0xCAFEF00D @0x200 with rst asserted during the first WAIT cycle → returns IDLE next cycle with Stall 0; a later LW @0x200 returns the prior contents, not 0xCAFEF00D.

Source files
------------

// File: rtl/data_mem_stage.sv
// data_mem_stage: memory-access stage for an RV32I pipeline.
// It takes the ALU result as a byte address and RD2 as store data. It performs
// byte, half and word loads and stores on an internal byte-addressed RAM.
// A wait-state FSM models memory latency and holds the front end with Stall.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   MemRead    load request
//   MemWrite   store request
//   funct3     access size / sign (RV32I encoding)
//   ALUResult  byte address (upper bits beyond ADDR_WIDTH ignored)
//   WriteData  store data, low bytes used for SB/SH
//   ReadData   registered, extended load result
//   Stall      upstream must hold PC and stage inputs while high
//   Valid      one-cycle pulse when an access completes
//   Error      one-cycle pulse for an illegal request (combinational)
//
// state | meaning
// IDLE  | waiting for a request; illegal requests flagged here
// WAIT  | counting down memory latency, access commits when count is 1
// DONE  | access finished, Valid pulse, inputs ignored
module data_mem_stage #(
  parameter int ADDR_WIDTH  = 17,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Valid,
  output logic        Error
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  logic [7:0] mem [0:(2**ADDR_WIDTH)-1];

  state_t state, state_next;
  logic [3:0] cnt, cnt_next;
  logic commit;

  logic [ADDR_WIDTH-1:0] addr;
  logic is_byte, is_half, is_word;
  logic load_ok, store_ok, misaligned, illegal, request;
  logic [3:0]  lane_mask;
  logic [31:0] lane_data;
  logic [31:0] rword, rshift, load_val;
  logic unused_addr_bits;

  assign addr             = ALUResult[ADDR_WIDTH-1:0];
  assign unused_addr_bits = ^ALUResult[31:ADDR_WIDTH];

  assign is_byte = (funct3[1:0] == 2'b00);
  assign is_half = (funct3[1:0] == 2'b01);
  assign is_word = (funct3[1:0] == 2'b10);

  assign load_ok  = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b101);
  assign store_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);

  assign misaligned = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
  assign request    = MemRead || MemWrite;
  assign illegal    = (MemRead && MemWrite) || misaligned ||
                      (MemRead ? !load_ok : !store_ok);

  // Store data is replicated across lanes so each lane can take its byte directly.
  always_comb begin
    lane_mask = 4'b0000;
    lane_data = WriteData;
    if (is_byte) begin
      lane_mask = 4'b0001 << addr[1:0];
      lane_data = {4{WriteData[7:0]}};
    end else if (is_half) begin
      lane_mask = addr[1] ? 4'b1100 : 4'b0011;
      lane_data = {2{WriteData[15:0]}};
    end else if (is_word) begin
      lane_mask = 4'b1111;
    end
  end

  assign rword  = {mem[{addr[ADDR_WIDTH-1:2], 2'd3}], mem[{addr[ADDR_WIDTH-1:2], 2'd2}],
                   mem[{addr[ADDR_WIDTH-1:2], 2'd1}], mem[{addr[ADDR_WIDTH-1:2], 2'd0}]};
  assign rshift = rword >> {addr[1:0], 3'b000};

  always_comb begin
    load_val = rword;
    case (funct3)
      3'b000:  load_val = {{24{rshift[7]}}, rshift[7:0]};
      3'b001:  load_val = {{16{rshift[15]}}, rshift[15:0]};
      3'b100:  load_val = {24'd0, rshift[7:0]};
      3'b101:  load_val = {16'd0, rshift[15:0]};
      default: load_val = rword;
    endcase
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    Stall      = 1'b0;
    Valid      = 1'b0;
    Error      = 1'b0;
    commit     = 1'b0;
    case (state)
      S_IDLE: begin
        if (request) begin
          if (illegal) begin
            Error = 1'b1;
          end else begin
            Stall = 1'b1;
            if (WAIT_CYCLES == 0) begin
              commit     = 1'b1;
              state_next = S_DONE;
            end else begin
              cnt_next   = WAIT_INIT;
              state_next = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        Stall    = 1'b1;
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) begin
          commit     = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        Valid      = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      ReadData <= 32'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (commit && MemRead) ReadData <= load_val;
    end
  end

  // RAM has no reset; rst simply blocks a commit that lands on the same edge.
  always_ff @(posedge clk) begin
    if (!rst && commit && MemWrite) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_mask[k]) mem[{addr[ADDR_WIDTH-1:2], 2'(k)}] <= lane_data[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_stage.sv
module tb_data_mem_stage;

  logic        clk;
  logic        rst;
  logic        mem_read  [2];
  logic        mem_write [2];
  logic [2:0]  f3        [2];
  logic [31:0] addr      [2];
  logic [31:0] wdata     [2];
  logic [31:0] rdata     [2];
  logic        stall     [2];
  logic        valid     [2];
  logic        err       [2];

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] sb_q [$];
  logic [31:0] last_rd [2];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  fn;
    logic [31:0] a;
    logic [31:0] wd;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [$];

  data_mem_stage #(.ADDR_WIDTH(17), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .MemRead(mem_read[0]), .MemWrite(mem_write[0]),
    .funct3(f3[0]), .ALUResult(addr[0]), .WriteData(wdata[0]),
    .ReadData(rdata[0]), .Stall(stall[0]), .Valid(valid[0]), .Error(err[0])
  );

  data_mem_stage #(.ADDR_WIDTH(17), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .MemRead(mem_read[1]), .MemWrite(mem_write[1]),
    .funct3(f3[1]), .ALUResult(addr[1]), .WriteData(wdata[1]),
    .ReadData(rdata[1]), .Stall(stall[1]), .Valid(valid[1]), .Error(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs(input int d);
    mem_read[d]  = 1'b0;
    mem_write[d] = 1'b0;
    f3[d]        = 3'b000;
    addr[d]      = 32'd0;
    wdata[d]     = 32'd0;
  endtask

  // Request is held through DONE; one cycle later it drops and the stage must stay idle.
  task automatic access(input int d, input logic rd, input logic wr, input logic [2:0] fn,
                        input logic [31:0] a, input logic [31:0] wd, input logic exp_err,
                        input logic [31:0] exp_rd, input int exp_stalls);
    int stalls;
    logic [31:0] want;
    @(negedge clk);
    mem_read[d]  = rd;
    mem_write[d] = wr;
    f3[d]        = fn;
    addr[d]      = a;
    wdata[d]     = wd;
    #1;
    if (exp_err) begin
      chk("err_pulse", 32'(err[d]), 32'd1);
      chk("err_stall", 32'(stall[d]), 32'd0);
      chk("err_valid", 32'(valid[d]), 32'd0);
      @(negedge clk);
      idle_inputs(d);
      #1;
      chk("err_after_stall", 32'(stall[d]), 32'd0);
      chk("err_after_valid", 32'(valid[d]), 32'd0);
      chk("err_after_err", 32'(err[d]), 32'd0);
      return;
    end
    if (rd) sb_q.push_back(exp_rd);
    stalls = 0;
    while (stall[d] && stalls < 40) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
    chk("done_valid", 32'(valid[d]), 32'd1);
    chk("done_err", 32'(err[d]), 32'd0);
    if (rd) begin
      if (sb_q.size() == 0) begin
        chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        want = sb_q.pop_front();
        chk("load_data", rdata[d], want);
        last_rd[d] = want;
      end
    end else begin
      chk("store_keeps_rdata", rdata[d], last_rd[d]);
    end
    @(negedge clk);
    idle_inputs(d);
    #1;
    chk("no_reissue_stall", 32'(stall[d]), 32'd0);
    chk("valid_single", 32'(valid[d]), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs(0);
    idle_inputs(1);
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;

    //                rd    wr    fn      addr          wdata          err   expected load
    tbl.push_back('{1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,         1'b0, 32'hDEAD_BEEF});
    tbl.push_back('{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,         1'b0, 32'hFFFF_FFDE});
    tbl.push_back('{1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,         1'b0, 32'h0000_00DE});
    tbl.push_back('{1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,         1'b0, 32'hFFFF_DEAD});
    tbl.push_back('{1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0,         1'b0, 32'h0000_DEAD});
    tbl.push_back('{1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h1234_5655, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,         1'b0, 32'hDEAD_55EF});
    tbl.push_back('{1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0,         1'b1, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 3'b001, 32'h0000_0101, 32'hFFFF_FFFF, 1'b1, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0,         1'b1, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'hFFFF_FFFF, 1'b1, 32'h0});
    tbl.push_back('{1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'hFFFF_FFFF, 1'b1, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,         1'b0, 32'hDEAD_55EF});
    tbl.push_back('{1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0,         1'b0, 32'h0000_0055});
    tbl.push_back('{1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h9999_8001, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,         1'b0, 32'h8001_55EF});
    tbl.push_back('{1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,         1'b0, 32'hFFFF_8001});
    tbl.push_back('{1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'h0,         1'b0, 32'h0000_55EF});
    tbl.push_back('{1'b1, 1'b0, 3'b000, 32'h0000_0100, 32'h0,         1'b0, 32'hFFFF_FFEF});
    tbl.push_back('{0, 1'b1, 3'b010, 32'h0002_0300, 32'h5566_7788, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0,         1'b0, 32'h5566_7788});
    tbl.push_back('{1'b0, 1'b1, 3'b010, 32'h0000_0200, 32'h1122_3344, 1'b0, 32'h0});

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_rdata", rdata[0], 32'd0);
    chk("reset_stall", 32'(stall[0]), 32'd0);
    chk("reset_valid", 32'(valid[0]), 32'd0);
    chk("reset_err", 32'(err[0]), 32'd0);
    chk("reset_rdata_w3", rdata[1], 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      access(0, tbl[i].rd, tbl[i].wr, tbl[i].fn, tbl[i].a, tbl[i].wd,
             tbl[i].exp_err, tbl[i].exp_rd, 2);
    end

    // Reset during the WAIT cycle lands on the store's commit edge: store must be dropped.
    @(negedge clk);
    mem_write[0] = 1'b1;
    f3[0]        = 3'b010;
    addr[0]      = 32'h0000_0200;
    wdata[0]     = 32'hCAFE_F00D;
    #1;
    chk("rst_seq_t0_stall", 32'(stall[0]), 32'd1);
    @(negedge clk);
    #1;
    chk("rst_seq_wait_stall", 32'(stall[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle_inputs(0);
    #1;
    chk("rst_seq_idle_stall", 32'(stall[0]), 32'd0);
    chk("rst_seq_idle_valid", 32'(valid[0]), 32'd0);
    chk("rst_seq_rdata", rdata[0], 32'd0);
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    access(0, 1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 1'b0, 32'h1122_3344, 2);

    // Three wait states: stall for four cycles, request held through DONE.
    access(1, 1'b0, 1'b1, 3'b010, 32'h0000_0000, 32'hA5A5_5A5A, 1'b0, 32'h0, 4);
    access(1, 1'b1, 1'b0, 3'b010, 32'h0000_0000, 32'h0, 1'b0, 32'hA5A5_5A5A, 4);
    access(1, 1'b1, 1'b0, 3'b001, 32'h0000_0002, 32'h0, 1'b0, 32'hFFFF_A5A5, 4);
    access(1, 1'b1, 1'b0, 3'b100, 32'h0000_0001, 32'h0, 1'b0, 32'h0000_005A, 4);

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
